uart_encoder: RTL and testbench
===============================

Name: uart_encoder

Overview:
- Synthesizable UART transmitter: the drive side for the SweRVolf `i_uart_rx` line, which the testbench currently ties to 1'b1.
- Accepts bytes on a valid/ready stream, buffers them in a small FIFO and serializes them as 8N1-style frames (parity and stop bits configurable).
- Used in the core testbench to inject console input, and in UART loopback benches alongside `uart_decoder`.

Parameters:
- CLK_FREQ_HZ, 25000000, clk frequency. 25 MHz matches the 40 ns testbench clock.
- BAUD_RATE, 115200, line rate. Internal DIV = CLK_FREQ_HZ/BAUD_RATE (integer division); elaboration error if DIV < 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even. Any other value is an elaboration error.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, byte buffer entries. Power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_data  in  8  byte to send.
- i_valid  in  1  i_data valid.
- o_ready  out  1  FIFO can accept. A push occurs on an edge where i_valid && o_ready.
- o_tx  out  1  serial line, idle high, registered.
- o_busy  out  1  FIFO non-empty or frame in progress.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (edge with rst=1): o_tx=1, o_busy=0, o_fifo_level=0, FIFO flushed, FSM IDLE, baud and bit counters 0.
- o_ready is combinational, equal to !full && !rst.
- FIFO:
  - Push while not full increments the level.
  - FSM pop decrements the level.
  - Push and pop on the same edge leaves the level unchanged, and data order is preserved.
  - A push is impossible when full because o_ready=0.
  - Read data is valid whenever the FIFO is non-empty (first-word fall-through).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx=1. On any edge with FIFO non-empty: pop into a shift register, o_tx<=0, go to START.
  - Latency: a byte pushed into an empty FIFO at edge k starts its start bit after edge k+1.
  - START: hold for DIV cycles, then o_tx<=data[0] and go to DATA.
  - DATA: each bit is held DIV cycles; bits go out LSB first, 8 bits total. After bit 7 go to PARITY if PARITY!=0, else to STOP.
  - PARITY: bit = ^data for even parity, ~^data for odd parity; held DIV cycles.
  - STOP: o_tx=1 for STOP_BITS*DIV cycles.
  - At the end of STOP, if the FIFO is non-empty: pop and drive the next start bit on the same edge (no idle gap, back-to-back). Otherwise go to IDLE.
- Every bit lasts exactly DIV cycles. Frame length = DIV*(10 + (PARITY!=0) + (STOP_BITS-1)).
- Baud counter counts 0..DIV-1 and reloads at each bit boundary. Bit counter is 3 bits. No fractional-baud accumulation: the rate error of the integer DIV is accepted.
- o_busy = (state!=IDLE) || (level!=0), registered-equivalent timing (no combinational path from i_valid).
- rst mid-frame: o_tx=1 from the next edge, partial frame abandoned, FIFO contents discarded, nothing resumes after rst deasserts.
- i_data is sampled only on push; changes while not pushing are ignored.

Decomposition:
- Shared package `uart_pkg`:
  - parity encodings PARITY_NONE/ODD/EVEN;
  - FSM state enum;
  - DIV computation function (shared with `uart_decoder` so both ends agree).
- One natural sub-module: `uart_tx_fifo`, a synchronous first-word fall-through FIFO (DEPTH, WIDTH=8), exposing full/empty/level.
- The top level holds the FSM, shift register, baud counter and bit counter.

Test Plan:
- DIV=4 (CLK_FREQ_HZ=460800, BAUD=115200), PARITY=0, STOP_BITS=1. Push 0x55 at edge k → o_tx low on cycles k+2..k+5. Then 1,0,1,0,1,0,1,0 (each 4 cycles). Then stop high 4 cycles. o_busy deasserts after cycle k+41. Total frame 40 cycles.
- Same DIV, PARITY=2. Send 0x07 → parity bit 1, frame 44 cycles. With PARITY=1 the parity bit is 0. With STOP_BITS=2 the stop high lasts 8 cycles.
- Back-to-back: push 0xA5 and 0x3C on consecutive edges. The second start bit falls exactly 40 cycles after the first, with no extra idle cycle. Loopback through `uart_decoder` prints both bytes.
- FIFO_DEPTH=4, i_valid held high with 5 bytes while the FSM is busy → o_ready=0 once level=4. The 5th byte is accepted only after a pop. All 5 bytes are transmitted in order.
- Assert rst for one cycle mid DATA bit 3 with 2 bytes still queued → o_tx=1 next edge, level=0, o_busy=0, line stays high for 100 cycles.
- Simultaneous push and pop with level=1 at a STOP end → level stays 1, and the pushed byte is sent after the popped byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and the
// baud divider computation used by both the encoder and the decoder.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  // Clocks per bit. Integer division: the resulting rate error is accepted.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word fall-through byte FIFO: rdata shows the oldest
// entry whenever the FIFO is non-empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];
  assign level = count;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_encoder.sv
// UART transmitter: buffers bytes from a valid/ready stream and serializes
// them as start / 8 data (LSB first) / optional parity / 1-2 stop bit frames.
module uart_encoder
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int unsigned DIV = uart_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned BW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("uart_encoder: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_encoder: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_encoder: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_encoder: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  uart_state_t state, state_nx;
  logic [BW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [2:0]    next_bit;
  logic [7:0]    tx_data, tx_data_nx;
  logic          tx_nx;
  logic          baud_end;
  logic          parity_bit;

  logic          push;
  logic          pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] level;

  assign o_ready      = !fifo_full && !rst;
  assign push         = i_valid && o_ready;
  assign o_fifo_level = level;
  assign o_busy       = (state != S_IDLE) || (level != '0);

  assign baud_end   = (baud_cnt == BW'(DIV - 1));
  assign next_bit   = bit_cnt + 3'd1;
  assign parity_bit = (PARITY == PARITY_EVEN) ? ^tx_data : ~^tx_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (i_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Next-state, next line value and FIFO pop for the frame sequencer.
  always_comb begin
    state_nx   = state;
    baud_nx    = baud_end ? '0 : baud_cnt + 1'b1;
    bit_nx     = bit_cnt;
    tx_data_nx = tx_data;
    tx_nx      = o_tx;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nx = '0;
        tx_nx   = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_data_nx = fifo_rdata;
          tx_nx      = 1'b0;
          bit_nx     = '0;
          state_nx   = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          tx_nx    = tx_data[0];
          bit_nx   = '0;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            bit_nx = '0;
            if (PARITY != PARITY_NONE) begin
              tx_nx    = parity_bit;
              state_nx = S_PARITY;
            end else begin
              tx_nx    = 1'b1;
              state_nx = S_STOP;
            end
          end else begin
            bit_nx = next_bit;
            tx_nx  = tx_data[next_bit];
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          tx_nx    = 1'b1;
          bit_nx   = '0;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            bit_nx = '0;
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) begin
              pop        = 1'b1;
              tx_data_nx = fifo_rdata;
              tx_nx      = 1'b0;
              state_nx   = S_START;
            end else begin
              tx_nx    = 1'b1;
              state_nx = S_IDLE;
            end
          end else begin
            bit_nx = next_bit;
          end
        end
      end
      default: begin
        tx_nx    = 1'b1;
        baud_nx  = '0;
        bit_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Sequencer registers, including the registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_data  <= '0;
      o_tx     <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      tx_data  <= tx_data_nx;
      o_tx     <= tx_nx;
    end
  end

endmodule

// File: tb/tb_uart_encoder.sv
// Scoreboard bench for uart_encoder at DIV=4: stimulus queues expected
// frames, per-instance monitors decode the line cycle by cycle and compare.
module tb_uart_encoder;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] rdy;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [2:0] lvl0;
  logic [4:0] lvl1, lvl2, lvl3;
  logic [4:0] lvl [4];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [11:0] exp_q   [3][$];
  int          start_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  assign lvl[0] = {2'b00, lvl0};
  assign lvl[1] = lvl1;
  assign lvl[2] = lvl2;
  assign lvl[3] = lvl3;

  // u0: no parity, 1 stop, depth 4
  uart_encoder #(.CLK_FREQ_HZ(460800), .BAUD_RATE(115200), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_fifo_level(lvl0));
  // u1: even parity
  uart_encoder #(.CLK_FREQ_HZ(460800), .BAUD_RATE(115200), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rst(rst), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_fifo_level(lvl1));
  // u2: odd parity, 2 stop bits
  uart_encoder #(.CLK_FREQ_HZ(460800), .BAUD_RATE(115200), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_fifo_level(lvl2));
  // u3: mid-frame reset target, own reset
  uart_encoder #(.CLK_FREQ_HZ(460800), .BAUD_RATE(115200), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u3 (
    .clk(clk), .rst(rst3), .i_data(data[3]), .i_valid(valid[3]),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_fifo_level(lvl3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Expected line bits, bit 0 first; unused upper bits are stop/idle ones.
  function automatic logic [11:0] frame(input logic [7:0] d, input int par);
    logic [11:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    if (par == 2) f[9] = (ones % 2 == 1);
    else if (par == 1) f[9] = (ones % 2 == 0);
    return f;
  endfunction

  function automatic int par_of(input int idx);
    return (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
  endfunction

  function automatic int pop_start(input int idx);
    if (start_q[idx].size() == 0) return -1;
    return start_q[idx].pop_front();
  endfunction

  // Drive one byte; returns the edge number at which it was accepted.
  task automatic push(input int idx, input logic [7:0] d, output int k);
    int n;
    if (idx < 3) exp_q[idx].push_back(frame(d, par_of(idx)));
    data[idx] = d;
    valid[idx] = 1'b1;
    n = 0;
    while (!rdy[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[idx]) begin
      checks++;
      errors++;
      $display("FAIL push_timeout[%0d]: o_ready stayed 0, expected 1", idx);
      valid[idx] = 1'b0;
      k = edge_n;
    end else begin
      @(negedge clk);
      k = edge_n;
      valid[idx] = 1'b0;
    end
  endtask

  task automatic wait_starts(input int idx, input int n, input int budget);
    int t;
    t = 0;
    while (start_q[idx].size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (start_q[idx].size() < n) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout[%0d]: got %0d frames, expected %0d", idx,
               start_q[idx].size(), n);
    end
  endtask

  task automatic busy_fall(input int idx, input int fall);
    while (edge_n < fall - 1) @(negedge clk);
    chk($sformatf("busy_before_end[%0d]", idx), busy[idx], 1);
    @(negedge clk);
    chk($sformatf("busy_after_end[%0d]", idx), busy[idx], 0);
  endtask

  // Monitor: on a start bit, sample every cycle of the frame and compare.
  task automatic monitor(input int idx, input int nbits);
    logic [11:0] e;
    logic [11:0] got;
    logic ok;
    int st;
    forever begin
      @(negedge clk);
      if (tx[idx] === 1'b0) begin
        st = edge_n;
        ok = 1'b1;
        got = '1;
        if (exp_q[idx].size() == 0) e = '1;
        else e = exp_q[idx].pop_front();
        for (int b = 0; b < nbits; b++) begin
          for (int c = 0; c < 4; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (tx[idx] !== e[b]) ok = 1'b0;
            if (c == 2) got[b] = tx[idx];
          end
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL frame[%0d] at edge %0d: got bits %03h, expected %03h",
                   idx, st, got, e);
        end
        start_q[idx].push_back(st);
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor(0, 10);
      monitor(1, 11);
      monitor(2, 12);
    join_none
  end

  initial begin
    int k, k2, s1, s2, s3;
    logic ok;
    rst = 1'b1;
    rst3 = 1'b1;
    valid = '0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx[%0d]", i), tx[i], 1);
      chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
      chk($sformatf("rst_level[%0d]", i), lvl[i], 0);
      chk($sformatf("rst_ready[%0d]", i), rdy[i], 0);
    end
    rst = 1'b0;
    rst3 = 1'b0;
    #1;
    chk("ready_after_rst", rdy[0], 1);
    @(negedge clk);

    // Single 0x55 frame: start after edge k+1, busy falls after edge k+41
    push(0, 8'h55, k);
    chk("level_after_push", lvl[0], 1);
    @(negedge clk);
    chk("level_after_pop", lvl[0], 0);
    chk("tx_start_bit", tx[0], 0);
    busy_fall(0, k + 41);
    wait_starts(0, 1, 20);
    chk("start_latency", pop_start(0), k + 1);

    // Parity variants of 0x07
    push(1, 8'h07, k);
    busy_fall(1, k + 45);
    wait_starts(1, 1, 20);
    chk("start_latency_even", pop_start(1), k + 1);
    push(2, 8'h07, k2);
    busy_fall(2, k2 + 49);
    wait_starts(2, 1, 20);
    chk("start_latency_odd2", pop_start(2), k2 + 1);

    // Back-to-back frames
    push(0, 8'hA5, k);
    push(0, 8'h3C, k2);
    wait_starts(0, 2, 120);
    s1 = pop_start(0);
    s2 = pop_start(0);
    chk("b2b_first_start", s1, k + 1);
    chk("b2b_gap", s2 - s1, 40);

    // Fill the depth-4 FIFO while a frame is in flight
    push(0, 8'h11, k);
    push(0, 8'h22, k2);
    push(0, 8'h33, k2);
    push(0, 8'h44, k2);
    push(0, 8'h55, k2);
    chk("full_level", lvl[0], 4);
    chk("full_ready", rdy[0], 0);
    push(0, 8'h66, k2);
    chk("fifth_accept_edge", k2, k + 42);
    chk("level_after_refill", lvl[0], 4);
    wait_starts(0, 6, 400);
    start_q[0].delete();

    // Push coinciding with the stop-end pop at level 1
    push(0, 8'hC3, k);
    push(0, 8'h81, k2);
    while (edge_n < k + 40) @(negedge clk);
    chk("level_before_stop_end", lvl[0], 1);
    exp_q[0].push_back(frame(8'h7E, 0));
    data[0] = 8'h7E;
    valid[0] = 1'b1;
    #1;
    chk("ready_at_stop_end", rdy[0], 1);
    @(negedge clk);
    valid[0] = 1'b0;
    chk("level_push_pop", lvl[0], 1);
    wait_starts(0, 3, 200);
    s1 = pop_start(0);
    s2 = pop_start(0);
    s3 = pop_start(0);
    chk("pp_gap1", s2 - s1, 40);
    chk("pp_gap2", s3 - s2, 40);

    // Reset during data bit 3 with two bytes queued
    push(3, 8'h00, k);
    push(3, 8'hFF, k2);
    push(3, 8'hFF, k2);
    while (edge_n < k + 18) @(negedge clk);
    chk("mid_tx_low", tx[3], 0);
    chk("mid_level", lvl[3], 2);
    rst3 = 1'b1;
    #1;
    chk("ready_in_rst3", rdy[3], 0);
    @(negedge clk);
    rst3 = 1'b0;
    chk("post_rst_tx", tx[3], 1);
    chk("post_rst_level", lvl[3], 0);
    chk("post_rst_busy", busy[3], 0);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx[3] !== 1'b1 || busy[3] !== 1'b0) ok = 1'b0;
    end
    chk("line_idle_100", ok, 1);

    // Everything queued must have been transmitted
    k = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pending_frames", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
